// File: rtl/multi_cycle_control_unit.sv
// rtl/multi_cycle_control_unit.sv - Moore FSM sequencing the multi-cycle MIPS datapath
// Outputs are decoded from the current state; only pc_write/ir_write/instr_done look at handshake inputs.
module multi_cycle_control_unit #(
  parameter int ALU_OP_W = 4,
  parameter bit ADDI_EN  = 1'b1,
  parameter bit JUMP_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                mem_ready,
  input  logic                alu_zero,
  output logic                pc_write,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          pc_source,
  output logic                instr_done,
  output logic                illegal_instr,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(4'd0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(4'd1);
  localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(4'd2);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(4'd3);
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = ALU_OP_W'(4'd4);
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(4'd5);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(4'd9);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(4'd10);

  state_t                r_state;
  state_t                w_next;
  logic                  w_pc_write;
  logic                  w_iord;
  logic                  w_mem_read;
  logic                  w_mem_write;
  logic                  w_ir_write;
  logic                  w_reg_dst;
  logic                  w_mem_to_reg;
  logic                  w_reg_write;
  logic                  w_alu_src_a;
  logic [1:0]            w_alu_src_b;
  logic [ALU_OP_W-1:0]   w_alu_op;
  logic [1:0]            w_pc_source;
  logic                  w_instr_done;
  logic                  w_illegal;

  always_comb begin
    w_next       = r_state;
    w_pc_write   = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = ALU_ADD;
    w_pc_source  = 2'b00;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is dispatched
        w_alu_src_b = 2'b11;
        if (opcode == OP_RTYPE)                        w_next = S_EXECUTE;
        else if (opcode == OP_LW || opcode == OP_SW)   w_next = S_MEM_ADDR;
        else if (opcode == OP_BEQ)                     w_next = S_BRANCH;
        else if (ADDI_EN && opcode == OP_ADDI)         w_next = S_ADDI_EX;
        else if (JUMP_EN && opcode == OP_J)            w_next = S_JUMP;
        else begin
          w_illegal = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_WRITE: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        if (mem_ready) begin
          w_instr_done = 1'b1;
          w_next       = S_FETCH;
        end
      end
      S_EXECUTE: begin
        w_alu_src_a = 1'b1;
        w_next      = S_ALU_WB;
        case (funct)
          6'h20, 6'h21: w_alu_op = ALU_ADD;
          6'h22, 6'h23: w_alu_op = ALU_SUB;
          6'h24:        w_alu_op = ALU_AND;
          6'h25:        w_alu_op = ALU_OR;
          6'h26:        w_alu_op = ALU_XOR;
          6'h27:        w_alu_op = ALU_NOR;
          6'h2a:        w_alu_op = ALU_SLT;
          6'h2b:        w_alu_op = ALU_SLTU;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_ALU_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = ALU_SUB;
        w_pc_source  = 2'b01;
        w_pc_write   = alu_zero;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_JUMP: begin
        w_pc_source  = 2'b10;
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_ADDI_EX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Gated by rst_n so a reset mid-instruction kills write strobes before any clock edge
  assign pc_write      = rst_n & w_pc_write;
  assign iord          = rst_n & w_iord;
  assign mem_read      = rst_n & w_mem_read;
  assign mem_write     = rst_n & w_mem_write;
  assign ir_write      = rst_n & w_ir_write;
  assign reg_dst       = rst_n & w_reg_dst;
  assign mem_to_reg    = rst_n & w_mem_to_reg;
  assign reg_write     = rst_n & w_reg_write;
  assign alu_src_a     = rst_n & w_alu_src_a;
  assign alu_src_b     = rst_n ? w_alu_src_b : 2'b00;
  assign alu_op        = rst_n ? w_alu_op : '0;
  assign pc_source     = rst_n ? w_pc_source : 2'b00;
  assign instr_done    = rst_n & w_instr_done;
  assign illegal_instr = rst_n & w_illegal;
  assign state         = rst_n ? r_state : 4'd0;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb/tb_multi_cycle_control_unit.sv - directed vector bench for multi_cycle_control_unit
module tb_multi_cycle_control_unit;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        mr;
    logic        az;
    logic [22:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] opcode, funct, opcode_n, funct_n;
  logic       mem_ready, alu_zero, mem_ready_n, alu_zero_n;

  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_op, state;
  logic       instr_done, illegal_instr;

  logic       pc_write_n, iord_n, mem_read_n, mem_write_n, ir_write_n, reg_dst_n, mem_to_reg_n, reg_write_n, alu_src_a_n;
  logic [1:0] alu_src_b_n, pc_source_n;
  logic [3:0] alu_op_n, state_n;
  logic       instr_done_n, illegal_instr_n;

  multi_cycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .instr_done(instr_done),
    .illegal_instr(illegal_instr), .state(state)
  );

  multi_cycle_control_unit #(.ALU_OP_W(4), .ADDI_EN(1'b0), .JUMP_EN(1'b0)) dut_na (
    .clk(clk), .rst_n(rst_n), .opcode(opcode_n), .funct(funct_n), .mem_ready(mem_ready_n), .alu_zero(alu_zero_n),
    .pc_write(pc_write_n), .iord(iord_n), .mem_read(mem_read_n), .mem_write(mem_write_n), .ir_write(ir_write_n),
    .reg_dst(reg_dst_n), .mem_to_reg(mem_to_reg_n), .reg_write(reg_write_n), .alu_src_a(alu_src_a_n),
    .alu_src_b(alu_src_b_n), .alu_op(alu_op_n), .pc_source(pc_source_n), .instr_done(instr_done_n),
    .illegal_instr(illegal_instr_n), .state(state_n)
  );

  logic [22:0] act, act_n;
  assign act   = {state, pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_instr};
  assign act_n = {state_n, pc_write_n, iord_n, mem_read_n, mem_write_n, ir_write_n, reg_dst_n, mem_to_reg_n,
                  reg_write_n, alu_src_a_n, alu_src_b_n, alu_op_n, pc_source_n, instr_done_n, illegal_instr_n};

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[$];

  // Argument order matches the packing of act: st pcw iord mrd mwr irw rdst m2r rw asa asb aop pcs done ill
  function automatic vec_t v(input logic [5:0] op, input logic [5:0] fn, input logic mr, input logic az,
                             input logic [3:0] st, input logic pcw, input logic io, input logic mrd,
                             input logic mwr, input logic irw, input logic rdst, input logic m2r,
                             input logic rw, input logic asa, input logic [1:0] asb, input logic [3:0] aop,
                             input logic [1:0] pcs, input logic done, input logic ill);
    vec_t r;
    r.op  = op;
    r.fn  = fn;
    r.mr  = mr;
    r.az  = az;
    r.exp = {st, pcw, io, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, pcs, done, ill};
    return r;
  endfunction

  function automatic vec_t vf(input logic [5:0] op, input logic [5:0] fn);
    return v(op, fn, 1, 0, 4'd0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 4'd0, 2'b00, 0, 0);
  endfunction

  function automatic vec_t vd(input logic [5:0] op, input logic [5:0] fn, input logic ill);
    return v(op, fn, 1, 0, 4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'd0, 2'b00, 0, ill);
  endfunction

  task automatic push_r(input logic [5:0] fn, input logic [3:0] aop);
    vecs.push_back(vf(6'h00, fn));
    vecs.push_back(vd(6'h00, fn, 0));
    vecs.push_back(v(6'h00, fn, 1, 0, 4'd6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, aop, 2'b00, 0, 0));
    vecs.push_back(v(6'h00, fn, 1, 0, 4'd7, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 4'd0, 2'b00, 1, 0));
  endtask

  task automatic check(input string name, input logic [22:0] got, input logic [22:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic apply(input vec_t x, input bit na, input string name);
    if (na) begin
      opcode_n = x.op; funct_n = x.fn; mem_ready_n = x.mr; alu_zero_n = x.az;
    end else begin
      opcode = x.op; funct = x.fn; mem_ready = x.mr; alu_zero = x.az;
    end
    @(negedge clk);
    check(name, na ? act_n : act, x.exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1; alu_zero = 1'b0;
    opcode_n = 6'h00; funct_n = 6'h20; mem_ready_n = 1'b0; alu_zero_n = 1'b0;

    push_r(6'h20, 4'd0);
    push_r(6'h22, 4'd1);
    push_r(6'h24, 4'd2);
    push_r(6'h25, 4'd3);
    push_r(6'h26, 4'd5);
    push_r(6'h27, 4'd4);
    push_r(6'h2a, 4'd9);
    push_r(6'h2b, 4'd10);
    push_r(6'h21, 4'd0);
    push_r(6'h23, 4'd1);
    // lw, no stalls
    vecs.push_back(vf(6'h23, 0));
    vecs.push_back(vd(6'h23, 0, 0));
    vecs.push_back(v(6'h23, 0, 1, 0, 4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'd0, 2'b00, 0, 0));
    vecs.push_back(v(6'h23, 0, 1, 0, 4'd3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 0, 0));
    vecs.push_back(v(6'h23, 0, 1, 0, 4'd4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 4'd0, 2'b00, 1, 0));
    // lw, two mem_ready-low cycles in MEM_READ: 7 cycles
    vecs.push_back(vf(6'h23, 0));
    vecs.push_back(vd(6'h23, 0, 0));
    vecs.push_back(v(6'h23, 0, 1, 0, 4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'd0, 2'b00, 0, 0));
    vecs.push_back(v(6'h23, 0, 0, 0, 4'd3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 0, 0));
    vecs.push_back(v(6'h23, 0, 0, 0, 4'd3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 0, 0));
    vecs.push_back(v(6'h23, 0, 1, 0, 4'd3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 0, 0));
    vecs.push_back(v(6'h23, 0, 1, 0, 4'd4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 4'd0, 2'b00, 1, 0));
    // sw
    vecs.push_back(vf(6'h2b, 0));
    vecs.push_back(vd(6'h2b, 0, 0));
    vecs.push_back(v(6'h2b, 0, 1, 0, 4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'd0, 2'b00, 0, 0));
    vecs.push_back(v(6'h2b, 0, 1, 0, 4'd5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 1, 0));
    // beq taken, then not taken
    vecs.push_back(vf(6'h04, 0));
    vecs.push_back(vd(6'h04, 0, 0));
    vecs.push_back(v(6'h04, 0, 1, 1, 4'd8, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'd1, 2'b01, 1, 0));
    vecs.push_back(vf(6'h04, 0));
    vecs.push_back(vd(6'h04, 0, 0));
    vecs.push_back(v(6'h04, 0, 1, 0, 4'd8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'd1, 2'b01, 1, 0));
    // j
    vecs.push_back(vf(6'h02, 0));
    vecs.push_back(vd(6'h02, 0, 0));
    vecs.push_back(v(6'h02, 0, 1, 0, 4'd9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 2'b10, 1, 0));
    // addi
    vecs.push_back(vf(6'h08, 0));
    vecs.push_back(vd(6'h08, 0, 0));
    vecs.push_back(v(6'h08, 0, 1, 0, 4'd10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'd0, 2'b00, 0, 0));
    vecs.push_back(v(6'h08, 0, 1, 0, 4'd11, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 4'd0, 2'b00, 1, 0));
    // FETCH stall: no ir_write/pc_write while mem_ready is low
    vecs.push_back(v(6'h00, 6'h20, 0, 0, 4'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 4'd0, 2'b00, 0, 0));
    push_r(6'h20, 4'd0);
    // illegal opcode, then illegal funct; each followed by a clean add to prove return to FETCH
    vecs.push_back(vf(6'h3f, 0));
    vecs.push_back(vd(6'h3f, 0, 1));
    push_r(6'h20, 4'd0);
    vecs.push_back(vf(6'h00, 6'h01));
    vecs.push_back(vd(6'h00, 6'h01, 0));
    vecs.push_back(v(6'h00, 6'h01, 1, 0, 4'd6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'd0, 2'b00, 0, 1));
    push_r(6'h24, 4'd2);

    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", act, 23'd0);
      check("reset_outputs_na", act_n, 23'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Reset during a stalled MEM_WRITE must drop mem_write without waiting for a clock edge
    apply(vf(6'h2b, 0), 1'b0, "sw_rst_fetch");
    apply(vd(6'h2b, 0, 0), 1'b0, "sw_rst_decode");
    apply(v(6'h2b, 0, 1, 0, 4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'd0, 2'b00, 0, 0), 1'b0, "sw_rst_addr");
    apply(v(6'h2b, 0, 0, 0, 4'd5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 0, 0), 1'b0, "sw_rst_wait");
    #2;
    check("sw_rst_before", act, {4'd5, 9'b010100000, 2'b00, 4'd0, 2'b00, 2'b00});
    rst_n = 1'b0;
    #1;
    check("sw_rst_async", act, 23'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_r(6'h20, 4'd0);
    for (int i = vecs.size() - 4; i < vecs.size(); i++) apply(vecs[i], 1'b0, $sformatf("post_rst%0d", i));

    // ADDI_EN=0 / JUMP_EN=0 instance treats addi and j as illegal
    apply(vf(6'h08, 0), 1'b1, "na_addi_fetch");
    apply(vd(6'h08, 0, 1), 1'b1, "na_addi_decode");
    apply(vf(6'h02, 0), 1'b1, "na_j_fetch");
    apply(vd(6'h02, 0, 1), 1'b1, "na_j_decode");
    apply(v(6'h00, 6'h20, 0, 0, 4'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 4'd0, 2'b00, 0, 0), 1'b1, "na_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
